// File: rtl/boot_pkg.sv
// boot_pkg: shared FSM state encoding and opcode field constants for the boot loader.
package boot_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam logic [5:0] HLT_OP = 6'b011101;
endpackage

// File: rtl/boot_loader.sv
// boot_loader: copies a program image from the HD store into IMEM until a hlt word or MAX_WORDS words.
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter longint unsigned MAX_WORDS = 64,
  parameter logic [5:0] HALT_OP = HLT_OP
) (
  input  logic              clk_auto,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  output logic [ADDR_W-1:0] hd_addr,
  input  logic [31:0]       hd_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              imem_we,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_loaded,
  output logic              overflow
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(MAX_WORDS - 1);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, base_q, base_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic              ovf_q, ovf_d;
  logic              is_halt, is_last;
  assign is_halt      = hd_data[OPCODE_MSB:OPCODE_LSB] == HALT_OP;
  assign is_last      = {1'b0, idx_q} == LAST;
  assign hd_addr      = base_q + idx_q;
  assign imem_addr    = idx_q;
  assign imem_data    = hd_data;
  assign imem_we      = state_q == WRITE;
  assign busy         = state_q == READ || state_q == WRITE;
  assign done         = state_q == DONE;
  assign words_loaded = wl_q;
  assign overflow     = ovf_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    wl_d    = wl_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        base_d  = src_base;
        idx_d   = '0;
        wl_d    = '0;
        ovf_d   = 1'b0;
      end
      READ: state_d = WRITE;
      WRITE: begin
        wl_d = {1'b0, idx_q} + 1'b1;
        // halt wins over the word limit, so a hlt in the last slot is not an overflow
        if (is_halt) begin
          state_d = DONE;
          ovf_d   = 1'b0;
        end else if (is_last) begin
          state_d = DONE;
          ovf_d   = 1'b1;
        end else begin
          state_d = READ;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_auto or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      wl_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      wl_q    <= wl_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
